// File: rtl/riscv_pkg.sv
// Shared RV32I constants: NOP encoding, default reset vector, opcodes and
// instruction field positions used by fetch and decode.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013; // addi x0,x0,0
    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // Field positions inside an instruction word
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned FUNC75_BIT = 30;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection (reset > redirect > stall > +4)
// and a sticky flag for redirects to a non-word-aligned target.
// Ports:
//   clk, rst (sync, active-low)
//   PCSrc, PCTarget : redirect request and target
//   Stall           : hold the PC
//   pc              : current PC register
//   addr_err        : sticky misaligned-redirect flag
module pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] PCTarget,
    input  logic                  Stall,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  addr_err
);

    logic [ADDR_WIDTH-1:0] pc_next_c;
    logic                  err_next_c;

    // Next-PC mux; a redirect overrides a stall and always lands word-aligned.
    always_comb begin
        pc_next_c  = pc + ADDR_WIDTH'(4);
        err_next_c = addr_err;
        if (PCSrc) begin
            pc_next_c = {PCTarget[ADDR_WIDTH-1:2], 2'b00};
            if (PCTarget[1:0] != 2'b00) begin
                err_next_c = 1'b1;
            end
        end else if (Stall) begin
            pc_next_c = pc;
        end
    end

    // PC and error flag state
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            addr_err <= 1'b0;
        end else begin
            pc       <= pc_next_c;
            addr_err <= err_next_c;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Ports:
//   clk, rst (sync, active-low)
//   PCSrc, PCTarget : redirect from control unit
//   Stall, Flush    : hazard-unit controls
//   InstrAddr       : instruction memory address (= PC)
//   Instr           : combinational instruction read data
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
//   opcode, funct3, func75        : decode fields sliced from InstrD
//   AddrErr         : sticky misaligned-redirect flag
//   FetchCount      : number of instructions accepted into IF/ID
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] PCTarget,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic [ADDR_WIDTH-1:0] InstrAddr,
    input  logic [INSTR_W-1:0]    Instr,
    output logic [INSTR_W-1:0]    InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic                  func75,
    output logic                  AddrErr,
    output logic [31:0]           FetchCount
);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  kill_c;
    logic                  load_c;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .PCSrc    (PCSrc),
        .PCTarget (PCTarget),
        .Stall    (Stall),
        .pc       (pc),
        .addr_err (AddrErr)
    );

    assign InstrAddr = pc;

    // Redirect or flush squashes the slot; otherwise load unless stalled.
    always_comb begin
        kill_c = PCSrc | Flush;
        load_c = !kill_c && !Stall;
    end

    // IF/ID register; a squashed slot holds a NOP so decode stays harmless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= RESET_PC;
            PCPlus4D <= RESET_PC + ADDR_WIDTH'(4);
            ValidD   <= 1'b0;
        end else if (kill_c) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end else if (load_c) begin
            InstrD   <= Instr;
            PCD      <= pc;
            PCPlus4D <= pc + ADDR_WIDTH'(4);
            ValidD   <= 1'b1;
        end
    end

    // Accepted-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (!rst) begin
            FetchCount <= 32'h0;
        end else if (load_c) begin
            FetchCount <= FetchCount + 32'd1;
        end
    end

    assign opcode = InstrD[OPCODE_MSB:OPCODE_LSB];
    assign funct3 = InstrD[FUNCT3_MSB:FUNCT3_LSB];
    assign func75 = InstrD[FUNC75_BIT];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RPC  = 32'hBFC0_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] K_INSTR = 32'h0050_0093;

    logic        clk;
    logic        rst;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        stall;
    logic        flush;
    logic        mem_mode;

    logic [31:0] instr_addr, instr, instr_d, pcd, pcp4d, fcount;
    logic        valid_d, addr_err, f75;
    logic [6:0]  opc;
    logic [2:0]  f3;

    logic [31:0] instr_addr2, instr_d2, pcd2, pcp4d2, fcount2;
    logic        valid_d2, addr_err2, f752;
    logic [6:0]  opc2;
    logic [2:0]  f32;

    int checks_total;
    int checks_passed;
    bit check_en;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
    logic        m_valid, m_err;

    // Instruction memory: constant word, or an address-dependent word
    function automatic logic [31:0] mem(input logic [31:0] a, input logic mode);
        return mode ? (a ^ 32'h4A5A_3000) : K_INSTR;
    endfunction

    assign instr = mem(instr_addr, mem_mode);

    fetch_stage dut (
        .clk(clk), .rst(rst), .PCSrc(pcsrc), .PCTarget(pctarget),
        .Stall(stall), .Flush(flush), .InstrAddr(instr_addr), .Instr(instr),
        .InstrD(instr_d), .PCD(pcd), .PCPlus4D(pcp4d), .ValidD(valid_d),
        .opcode(opc), .funct3(f3), .func75(f75), .AddrErr(addr_err),
        .FetchCount(fcount)
    );

    fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .PCSrc(1'b0), .PCTarget(32'h0),
        .Stall(1'b0), .Flush(1'b0), .InstrAddr(instr_addr2), .Instr(K_INSTR),
        .InstrD(instr_d2), .PCD(pcd2), .PCPlus4D(pcp4d2), .ValidD(valid_d2),
        .opcode(opc2), .funct3(f32), .func75(f752), .AddrErr(addr_err2),
        .FetchCount(fcount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: an edge either resets, squashes, holds or accepts the word at PC.
    always @(posedge clk) begin
        if (!rst) begin
            m_pc = RPC; m_valid = 1'b0; m_instr = NOPI;
            m_pcd = RPC; m_pcp4 = RPC + 32'd4; m_err = 1'b0; m_cnt = 32'd0;
        end else begin
            if (pcsrc || flush) begin
                m_valid = 1'b0;
                m_instr = NOPI;
            end else if (!stall) begin
                m_valid = 1'b1;
                m_instr = mem(m_pc, mem_mode);
                m_pcd   = m_pc;
                m_pcp4  = m_pc + 32'd4;
                m_cnt   = m_cnt + 32'd1;
            end
            if (pcsrc) begin
                if (pctarget % 4 != 0) m_err = 1'b1;
                m_pc = pctarget - (pctarget % 4);
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_instr_addr", instr_addr, m_pc);
            chk("m_valid",      {31'h0, valid_d}, {31'h0, m_valid});
            chk("m_instr_d",    instr_d, m_instr);
            chk("m_pcd",        pcd, m_pcd);
            chk("m_pcplus4d",   pcp4d, m_pcp4);
            chk("m_opcode",     {25'h0, opc}, {25'h0, m_instr[6:0]});
            chk("m_funct3",     {29'h0, f3}, {29'h0, m_instr[14:12]});
            chk("m_func75",     {31'h0, f75}, {31'h0, m_instr[30]});
            chk("m_addr_err",   {31'h0, addr_err}, {31'h0, m_err});
            chk("m_fetch_cnt",  fcount, m_cnt);
        end
    end

    // Apply inputs for the next edge, then return at the following negedge
    task automatic cycle(input logic r, input logic src, input logic [31:0] tgt,
                         input logic st, input logic fl);
        rst = r; pcsrc = src; pctarget = tgt; stall = st; flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks_total = 0; checks_passed = 0; check_en = 1'b0;
        rst = 1'b0; pcsrc = 1'b0; pctarget = 32'h0; stall = 1'b0; flush = 1'b0;
        mem_mode = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_en = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_instr_addr", instr_addr, 32'hBFC0_0000);
        chk("rst_valid",      {31'h0, valid_d}, 32'h0);
        chk("rst_instr_d",    instr_d, 32'h0000_0013);
        chk("rst_pcplus4d",   pcp4d, 32'hBFC0_0004);
        chk("rst_cnt",        fcount, 32'h0);
        chk("wrap_rst_addr",  instr_addr2, 32'hFFFF_FFFC);
        chk("wrap_rst_pcp4",  pcp4d2, 32'h0);

        // Free run with a constant instruction word
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("run_valid",      {31'h0, valid_d}, 32'h1);
        chk("run_pcd",        pcd, 32'hBFC0_0000);
        chk("run_opcode",     {25'h0, opc}, 32'h13);
        chk("run_instr_d",    instr_d, 32'h0050_0093);
        chk("wrap_next_addr", instr_addr2, 32'h0);
        chk("wrap_pcd",       pcd2, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("run_cnt3",       fcount, 32'd3);
        chk("run_pcd3",       pcd, 32'hBFC0_0008);
        chk("run_addr3",      instr_addr, 32'hBFC0_000C);

        // Redirect with address-dependent instruction words
        mem_mode = 1'b1;
        cycle(1'b1, 1'b1, 32'hBFC0_0100, 1'b0, 1'b0);
        chk("redir_addr",     instr_addr, 32'hBFC0_0100);
        chk("redir_bubble",   {31'h0, valid_d}, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_pcd",      pcd, 32'hBFC0_0100);
        chk("redir_valid",    {31'h0, valid_d}, 32'h1);
        chk("redir_instr",    instr_d, 32'hF59A_3100);

        // Stall for three cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            chk("stall_addr",  instr_addr, 32'hBFC0_0104);
            chk("stall_pcd",   pcd, 32'hBFC0_0100);
            chk("stall_cnt",   fcount, 32'd4);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("unstall_pcd",    pcd, 32'hBFC0_0104);
        chk("unstall_cnt",    fcount, 32'd5);

        // Stall + Flush, then Stall + PCSrc
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("sf_valid",       {31'h0, valid_d}, 32'h0);
        chk("sf_instr",       instr_d, 32'h0000_0013);
        chk("sf_addr",        instr_addr, 32'hBFC0_0108);
        cycle(1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 1'b0);
        chk("sp_addr",        instr_addr, 32'hBFC0_0200);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("sp_pcd",         pcd, 32'hBFC0_0200);

        // Misaligned redirect, sticky error
        cycle(1'b1, 1'b1, 32'hBFC0_0102, 1'b0, 1'b0);
        chk("mis_addr",       instr_addr, 32'hBFC0_0100);
        chk("mis_err",        {31'h0, addr_err}, 32'h1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hBFC0_0300, 1'b0, 1'b0);
        chk("mis_sticky",     {31'h0, addr_err}, 32'h1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_addr",     instr_addr, 32'hBFC0_0308);
        chk("flush_cnt",      fcount, 32'd8);

        // Reset coincident with redirect and stall
        cycle(1'b0, 1'b1, 32'hBFC0_0400, 1'b1, 1'b0);
        chk("rr_addr",        instr_addr, 32'hBFC0_0000);
        chk("rr_valid",       {31'h0, valid_d}, 32'h0);
        chk("rr_err",         {31'h0, addr_err}, 32'h0);
        chk("rr_cnt",         fcount, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rr_resume_pcd",  pcd, 32'hBFC0_0004);

        check_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
